// File: rtl/mac_pkg.sv
// Shared definitions for the systolic MAC processing element and its
// self-test window controller.
package mac_pkg;

  // Default operand / accumulator width
  localparam int WORD_SIZE_DEF = 16;

  // Self-test window sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    CHECK   = 2'd2
  } stw_state_t;

endpackage

// File: rtl/mac_stw_ctrl.sv
// Self-test window controller: holds the preloaded test operands, sequences
// IDLE -> COMPUTE -> CHECK, captures the datapath sum and compares it with
// the expected value. It steers the shared multiplier/adder via stw_sel_o.
module mac_stw_ctrl
  import mac_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,          // synchronous, active low
  input  logic                 load_en_i,
  input  logic                 start_i,
  input  logic [WORD_SIZE-1:0] op1_i,
  input  logic [WORD_SIZE-1:0] op2_i,
  input  logic [WORD_SIZE-1:0] add_i,
  input  logic [WORD_SIZE-1:0] exp_i,
  input  logic [WORD_SIZE-1:0] sum_i,        // shared adder output
  output logic                 stw_sel_o,    // 1 = datapath fed test operands
  output logic                 acc_en_o,     // 1 = accumulator may update
  output logic [WORD_SIZE-1:0] stw_op1_o,
  output logic [WORD_SIZE-1:0] stw_op2_o,
  output logic [WORD_SIZE-1:0] stw_add_o,
  output logic                 complete_o,
  output logic                 result_o
);

  stw_state_t           state_q;
  logic [WORD_SIZE-1:0] op1_q;
  logic [WORD_SIZE-1:0] op2_q;
  logic [WORD_SIZE-1:0] add_q;
  logic [WORD_SIZE-1:0] exp_q;
  logic [WORD_SIZE-1:0] res_q;
  logic                 complete_q;
  logic                 result_q;

  // Test FSM, operand latches, result capture and compare in one process
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      add_q      <= '0;
      exp_q      <= '0;
      res_q      <= '0;
      complete_q <= 1'b0;
      result_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A load in the same cycle as a start wins; the start is dropped.
          if (load_en_i) begin
            op1_q      <= op1_i;
            op2_q      <= op2_i;
            add_q      <= add_i;
            exp_q      <= exp_i;
            complete_q <= 1'b0;
            result_q   <= 1'b0;
          end else if (start_i) begin
            complete_q <= 1'b0;
            result_q   <= 1'b0;
            state_q    <= COMPUTE;
          end
        end
        COMPUTE: begin
          res_q   <= sum_i;
          state_q <= CHECK;
        end
        CHECK: begin
          complete_q <= 1'b1;
          result_q   <= (res_q != exp_q);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stw_sel_o  = (state_q == COMPUTE);
  assign acc_en_o   = (state_q == IDLE);
  assign stw_op1_o  = op1_q;
  assign stw_op2_o  = op2_q;
  assign stw_add_o  = add_q;
  assign complete_o = complete_q;
  assign result_o   = result_q;

endmodule

// File: rtl/traditional_mac_stw.sv
// Systolic-array MAC processing element with operand forwarding, optional
// stationary weight and a built-in self-test window that exercises the
// same multiplier and adder used for accumulation.
module traditional_mac_stw
  import mac_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ENABLE_FI = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fsm_op2_select_in,
  input  logic                 fsm_out_select_in,
  input  logic                 stat_bit_in,
  input  logic [WORD_SIZE-1:0] left_in,
  input  logic [WORD_SIZE-1:0] top_in,
  input  logic                 fault_inject,
  input  logic                 STW_test_load_en,
  input  logic [WORD_SIZE-1:0] STW_mult_op1,
  input  logic [WORD_SIZE-1:0] STW_mult_op2,
  input  logic [WORD_SIZE-1:0] STW_add_op,
  input  logic [WORD_SIZE-1:0] STW_expected,
  input  logic                 STW_start,
  output logic [WORD_SIZE-1:0] right_out,
  output logic [WORD_SIZE-1:0] bottom_out,
  output logic                 STW_complete,
  output logic                 STW_result_out
);

  localparam bit FI_ON = (ENABLE_FI != 0);

  logic [WORD_SIZE-1:0] left_q;
  logic [WORD_SIZE-1:0] top_q;
  logic [WORD_SIZE-1:0] acc_q;
  logic [WORD_SIZE-1:0] weight_q;

  logic                 stw_sel;
  logic                 acc_en;
  logic [WORD_SIZE-1:0] stw_op1;
  logic [WORD_SIZE-1:0] stw_op2;
  logic [WORD_SIZE-1:0] stw_add;

  logic [WORD_SIZE-1:0] mult_a;
  logic [WORD_SIZE-1:0] mult_b;
  logic [WORD_SIZE-1:0] mult_raw;
  logic [WORD_SIZE-1:0] product;
  logic [WORD_SIZE-1:0] addend;
  logic [WORD_SIZE-1:0] sum;
  logic                 fi_active;

  // Shared arithmetic: during COMPUTE the test operands replace the normal
  // ones so the self-test covers the very multiplier/adder in use.
  assign mult_a    = stw_sel ? stw_op1 : left_in;
  assign mult_b    = stw_sel ? stw_op2 : (fsm_op2_select_in ? weight_q : top_in);
  assign mult_raw  = mult_a * mult_b;
  assign fi_active = FI_ON & fault_inject;
  assign product   = {mult_raw[WORD_SIZE-1:1], mult_raw[0] ^ fi_active};
  assign addend    = stw_sel ? stw_add : acc_q;
  assign sum       = addend + product;

  // Forwarding registers, accumulator and stationary weight
  always_ff @(posedge clk) begin
    if (!rst) begin
      left_q   <= '0;
      top_q    <= '0;
      acc_q    <= '0;
      weight_q <= '0;
    end else begin
      left_q <= left_in;
      top_q  <= top_in;
      if (acc_en) begin
        acc_q <= sum;
      end
      if (stat_bit_in) begin
        weight_q <= top_in;
      end
    end
  end

  assign right_out  = left_q;
  assign bottom_out = fsm_out_select_in ? acc_q : top_q;

  mac_stw_ctrl #(
    .WORD_SIZE (WORD_SIZE)
  ) u_stw_ctrl (
    .clk        (clk),
    .rst        (rst),
    .load_en_i  (STW_test_load_en),
    .start_i    (STW_start),
    .op1_i      (STW_mult_op1),
    .op2_i      (STW_mult_op2),
    .add_i      (STW_add_op),
    .exp_i      (STW_expected),
    .sum_i      (sum),
    .stw_sel_o  (stw_sel),
    .acc_en_o   (acc_en),
    .stw_op1_o  (stw_op1),
    .stw_op2_o  (stw_op2),
    .stw_add_o  (stw_add),
    .complete_o (STW_complete),
    .result_o   (STW_result_out)
  );

endmodule

// File: tb/tb_traditional_mac_stw.sv
// Randomized and directed bench for the MAC PE with self-test window.
// Reference model works on plain integers: products/sums masked to 16 bits,
// the self-test tracked as a countdown of cycles remaining.
module tb_traditional_mac_stw;

  localparam int          W    = 16;
  localparam int unsigned MASK = 32'h0000_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         op2_sel, out_sel, stat;
  logic [W-1:0] left_in, top_in;
  logic         fault_inject;
  logic         load_en, start;
  logic [W-1:0] s_op1, s_op2, s_add, s_exp;
  logic [W-1:0] right_out, bottom_out;
  logic         stw_complete, stw_result;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int unsigned m_left, m_top, m_acc, m_w;
  int unsigned m_op1, m_op2, m_add, m_exp, m_res;
  int          m_busy;   // self-test cycles still to go (0 = idle)
  bit          m_cmp, m_fail;

  always #5 clk = ~clk;

  traditional_mac_stw #(
    .WORD_SIZE (W),
    .ENABLE_FI (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fsm_op2_select_in (op2_sel),
    .fsm_out_select_in (out_sel),
    .stat_bit_in       (stat),
    .left_in           (left_in),
    .top_in            (top_in),
    .fault_inject      (fault_inject),
    .STW_test_load_en  (load_en),
    .STW_mult_op1      (s_op1),
    .STW_mult_op2      (s_op2),
    .STW_add_op        (s_add),
    .STW_expected      (s_exp),
    .STW_start         (start),
    .right_out         (right_out),
    .bottom_out        (bottom_out),
    .STW_complete      (stw_complete),
    .STW_result_out    (stw_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_update();
    int unsigned b, p, p2;
    if (!rst) begin
      m_left = 0; m_top = 0; m_acc = 0; m_w = 0;
      m_op1 = 0; m_op2 = 0; m_add = 0; m_exp = 0; m_res = 0;
      m_busy = 0; m_cmp = 0; m_fail = 0;
      return;
    end
    b = op2_sel ? m_w : 32'(top_in);
    p = (32'(left_in) * b) & MASK;
    if (fault_inject) p = p ^ 1;
    if (m_busy == 0) begin
      m_acc = (m_acc + p) & MASK;
      if (load_en) begin
        m_op1 = s_op1; m_op2 = s_op2; m_add = s_add; m_exp = s_exp;
        m_cmp = 0; m_fail = 0;
      end else if (start) begin
        m_busy = 2; m_cmp = 0; m_fail = 0;
      end
    end else if (m_busy == 2) begin
      p2 = (m_op1 * m_op2) & MASK;
      if (fault_inject) p2 = p2 ^ 1;
      m_res  = (p2 + m_add) & MASK;
      m_busy = 1;
    end else begin
      m_cmp  = 1;
      m_fail = (m_res != m_exp);
      m_busy = 0;
    end
    if (stat) m_w = top_in;
    m_left = left_in;
    m_top  = top_in;
  endtask

  // One clock with model update and full output comparison
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("right_out", right_out, m_left);
    check("bottom_out", bottom_out, out_sel ? m_acc : m_top);
    check("stw_complete", stw_complete, m_cmp);
    check("stw_result", stw_result, m_fail);
  endtask

  task automatic load_stw(input int unsigned a, input int unsigned b,
                          input int unsigned c, input int unsigned d);
    s_op1 = W'(a); s_op2 = W'(b); s_add = W'(c); s_exp = W'(d);
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  // Pulse start and wait the two edges until the verdict is valid
  task automatic run_stw();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  initial begin
    int unsigned v;
    rst = 1'b0; op2_sel = 0; out_sel = 0; stat = 0;
    left_in = '0; top_in = '0; fault_inject = 0;
    load_en = 0; start = 0;
    s_op1 = '0; s_op2 = '0; s_add = '0; s_exp = '0;
    #1;

    // Reset with busy inputs
    left_in = 16'h1234; top_in = 16'h5678; stat = 1; out_sel = 1;
    load_en = 1; start = 1;
    step(); step();
    check("rst_right", right_out, 0);
    check("rst_bottom", bottom_out, 0);
    check("rst_complete", stw_complete, 0);
    check("rst_result", stw_result, 0);
    load_en = 0; start = 0; stat = 0; out_sel = 0;
    $display("reset phase done");

    // Passing self-test with passthrough forwarding
    rst = 1'b1; left_in = 3; top_in = 3;
    load_stw(2, 3, 0, 6);
    run_stw();
    check("pass_complete", stw_complete, 1);
    check("pass_result", stw_result, 0);
    check("pass_right", right_out, 3);
    check("pass_bottom", bottom_out, 3);
    $display("stw 2*3+0 vs 6 -> complete=%0b result=%0b", stw_complete, stw_result);

    // Failing self-test: 7 != 6
    load_stw(2, 3, 1, 6);
    check("load_clears", stw_complete, 0);
    run_stw();
    check("fail_complete", stw_complete, 1);
    check("fail_result", stw_result, 1);
    $display("stw 2*3+1 vs 6 -> complete=%0b result=%0b", stw_complete, stw_result);

    // Fault injection flips the product LSB
    fault_inject = 1;
    load_stw(2, 3, 0, 6);
    run_stw();
    check("fi_result", stw_result, 1);
    fault_inject = 0;
    run_stw();
    check("nofi_result", stw_result, 0);
    $display("fault injection stw -> result=%0b", stw_result);

    // Accumulate and wrap
    rst = 1'b0; step(); rst = 1'b1;
    out_sel = 1; left_in = 3; top_in = 3;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("acc_seq", bottom_out, 9 * i);
    end
    left_in = 16'hFFFF; top_in = 16'hFFFF;
    step();
    check("acc_wrap", bottom_out, 37);
    left_in = 3; top_in = 3;
    run_stw();
    check("acc_frozen", bottom_out, 46);
    step();
    check("acc_resume", bottom_out, 55);
    $display("accumulate phase acc=%0d", bottom_out);

    // Stationary weight
    rst = 1'b0; step(); rst = 1'b1;
    stat = 1; top_in = 5; left_in = 0; op2_sel = 0;
    step();
    stat = 0; op2_sel = 1; left_in = 2; top_in = 7;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("weight_acc", bottom_out, 10 * i);
    end
    $display("stationary weight phase acc=%0d", bottom_out);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 99) != 0);
      op2_sel      = 1'($urandom);
      out_sel      = 1'($urandom);
      stat         = ($urandom_range(0, 3) == 0);
      left_in      = W'($urandom);
      top_in       = W'($urandom);
      fault_inject = ($urandom_range(0, 3) == 0);
      load_en      = ($urandom_range(0, 7) == 0);
      start        = ($urandom_range(0, 4) == 0);
      s_op1        = W'($urandom);
      s_op2        = W'($urandom);
      s_add        = W'($urandom);
      v            = ((32'(s_op1) * 32'(s_op2)) + 32'(s_add)) & MASK;
      s_exp        = ($urandom_range(0, 1) != 0) ? W'(v) : W'($urandom);
      step();
    end
    load_en = 0; start = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traditional_mac_stw.md
Name: traditional_mac_stw

Overview:
- Single processing element (PE) of the systolic-array MAC grid.
- Forwards left/top operands to its right/bottom neighbours and accumulates products, using either the top operand or a stationary weight.
- Includes a Self-Test Window (STW) mode: preloaded test operands go through the PE's own multiplier and adder, the result is compared to an expected value, and a fault flag is reported for the BISR repair logic.

Parameters:
- WORD_SIZE, 16, width of every data operand, the accumulator and the STW operands.
- ENABLE_FI, 0, when 1 the fault_inject input corrupts the multiplier output; when 0 fault_inject is ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- fsm_op2_select_in  in  1  multiplier operand 2 select: 0 = top_in, 1 = stationary weight register.
- fsm_out_select_in  in  1  bottom_out select: 0 = forwarded top operand, 1 = accumulator.
- stat_bit_in  in  1  1 = load the stationary weight register from top_in this cycle.
- left_in  in  WORD_SIZE  operand from the left neighbour (multiplier op1).
- top_in  in  WORD_SIZE  operand from the top neighbour.
- fault_inject  in  1  fault injection enable (only active when ENABLE_FI=1).
- STW_test_load_en  in  1  latch the four STW operand inputs.
- STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected  in  WORD_SIZE each  test multiplicand, multiplier, addend and expected result.
- STW_start  in  1  single-cycle pulse that starts a self-test.
- right_out  out  WORD_SIZE  registered left_in.
- bottom_out  out  WORD_SIZE  registered top_in or the accumulator, per fsm_out_select_in.
- STW_complete  out  1  self-test finished; result is valid.
- STW_result_out  out  1  1 = mismatch (fault detected), 0 = pass.

Behaviour:
- Reset (rst=0 at a clock edge) clears to 0: left_reg, top_reg, acc, weight_reg, all STW registers, right_out, bottom_out, STW_complete, STW_result_out; FSM goes to IDLE. Reset mid-test aborts the test with no result.
- Arithmetic: product = left_in * op2 and sum = acc + product, both truncated to the low WORD_SIZE bits (modulo 2^WORD_SIZE, no saturation).
- Forwarding path, every non-reset cycle in all FSM states:
  - left_reg <= left_in; top_reg <= top_in.
  - right_out = left_reg; bottom_out = fsm_out_select_in ? acc : top_reg.
  - Combinational mux on registered values; one-cycle forwarding latency.
- Accumulation (IDLE only): acc <= acc + left_in*op2 every cycle.
- stat_bit_in=1: weight_reg <= top_in; this is independent of FSM state.
- Fault injection: with ENABLE_FI=1 and fault_inject=1, the multiplier output LSB is inverted. This applies in both normal and STW operation.
- STW_test_load_en=1 in IDLE latches the four STW operands. It is ignored outside IDLE. It also clears STW_complete and STW_result_out.
- STW FSM:
  - IDLE: STW_start=1 -> COMPUTE. If STW_start and STW_test_load_en are asserted in the same cycle, the load happens and the start is ignored.
  - COMPUTE (1 cycle): multiplier is fed STW_mult_op1/STW_mult_op2; adder is fed product + STW_add_op; stw_result register <= sum. acc is not updated. -> CHECK.
  - CHECK (1 cycle): STW_complete <= 1; STW_result_out <= (stw_result != STW_expected). -> IDLE.
- Latency: with STW_start sampled at edge N, STW_complete and STW_result_out are valid after edge N+2.
- STW_complete and STW_result_out hold until the next STW load, the next STW_start (which clears both), or reset.
- STW_start pulses in COMPUTE or CHECK are ignored.

Decomposition:
- Shared package mac_pkg: WORD_SIZE default, and an enum stw_state_t {IDLE, COMPUTE, CHECK}.
- One natural sub-module: mac_stw_ctrl, holding the STW operand registers, the FSM and the comparator. It drives the operand-mux selects into the datapath.

Test Plan:
- Reset: hold rst=0 for 2 cycles with nonzero inputs -> all outputs 0, STW_complete=0.
- Passthrough STW pass:
  - Stimulus: op2_sel=0, out_sel=0, stat=0, left=3, top=3; load op1=2, op2=3, add=0, expected=6; pulse start.
  - Required: STW_complete=1, STW_result_out=0 two edges after start; right_out=3, bottom_out=3 throughout.
- STW fail: load 2,3,1,6; start -> STW_result_out=1 (7≠6), STW_complete=1.
- Fault injection (ENABLE_FI=1): fault_inject=1, load 2,3,0,6 -> STW_result_out=1. With fault_inject=0 -> 0.
- Accumulate and wrap:
  - Stimulus: out_sel=1, left=3, top=3 for 4 cycles.
  - Required: bottom_out = 9, 18, 27, 36. Then left=top=0xFFFF for 1 cycle adds 1 (mod 2^16).
  - acc is frozen during COMPUTE/CHECK.
- Stationary weight: stat=1 with top=5 for 1 cycle, then op2_sel=1, left=2, top=7 -> acc grows by 10 per cycle.
